// File: rtl/fpu_sequencer.sv
// fpu_sequencer: command FSM that loads R1/R2, pulses fpu_add/fpu_sub and writes the result back to R1
// FPU_SEQ_CMD_QUEUE_EN adds a 2-entry in-order command FIFO in front of the FSM
module fpu_sequencer #(
    parameter int ADD_LAT = 5,
    parameter int SUB_LAT = 6,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [6:0]  cmd_e,
    input  logic [14:0] cmd_m,
    output logic        res_valid,
    output logic [6:0]  res_e,
    output logic [14:0] res_m,
    output logic        busy,
    output logic        fpu_rst,
    output logic        fpu_add,
    output logic        fpu_sub,
    output logic [6:0]  fpu_reg1_e,
    output logic [14:0] fpu_reg1_m,
    output logic [6:0]  fpu_reg2_e,
    output logic [14:0] fpu_reg2_m,
    input  logic [6:0]  fpu_res_e,
    input  logic [14:0] fpu_res_m,
    input  logic        fpu_idle
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WRITE} state_t;
    state_t state, state_nx;
    logic [6:0] r1_e, r2_e;
    logic [14:0] r1_m, r2_m;
    logic [CNT_W-1:0] cnt;
    logic op_sub;
    logic hv, go, start;
    logic [2:0] hop;
    logic [6:0] he;
    logic [14:0] hm;

    assign go    = hv & (state == IDLE) & fpu_idle & !fpu_rst;
    assign start = go & (hop == 3'd3 | hop == 3'd4);

`ifdef FPU_SEQ_CMD_QUEUE_EN
    logic [24:0] q [2];
    logic wp, rp, push;
    logic [1:0] fill;

    assign cmd_ready = fill != 2'd2;
    assign push = cmd_valid & cmd_ready;
    assign hv = fill != 2'd0;
    assign {hop, he, hm} = q[rp];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= 1'b0;
            rp <= 1'b0;
            fill <= 2'd0;
            q[0] <= '0;
            q[1] <= '0;
        end else begin
            if (push) q[wp] <= {cmd_op, cmd_e, cmd_m};
            wp <= wp ^ push;
            rp <= rp ^ go;
            fill <= fill + {1'b0, push} - {1'b0, go};
        end
    end
`else
    assign cmd_ready = (state == IDLE) & fpu_idle & !fpu_rst;
    assign hv  = cmd_valid;
    assign hop = cmd_op;
    assign he  = cmd_e;
    assign hm  = cmd_m;
`endif

    always_comb begin
        state_nx = state == IDLE  ? (start ? ISSUE : IDLE) :
                   state == ISSUE ? WAIT :
                   state == WAIT  ? (cnt == CNT_W'(1) ? WRITE : WAIT) : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            {r1_e, r1_m} <= '0;
            {r2_e, r2_m} <= '0;
            {res_e, res_m} <= '0;
            cnt <= '0;
            op_sub <= 1'b0;
            res_valid <= 1'b0;
            fpu_rst <= 1'b1;
        end else begin
            state <= state_nx;
            fpu_rst <= 1'b0;
            res_valid <= 1'b0;
            if (go && hop == 3'd1) {r1_e, r1_m} <= {he, hm};
            if (go && hop == 3'd2) {r2_e, r2_m} <= {he, hm};
            if (go && hop == 3'd5) begin
                {res_e, res_m} <= {r1_e, r1_m};
                res_valid <= 1'b1;
            end
            if (start) op_sub <= hop == 3'd4;
            if (state == ISSUE) cnt <= op_sub ? CNT_W'(SUB_LAT) : CNT_W'(ADD_LAT);
            else if (state == WAIT) cnt <= cnt - CNT_W'(1);
            // operands stay frozen until this write-back, so the fpu sees stable inputs
            if (state == WRITE) begin
                {r1_e, r1_m} <= {fpu_res_e, fpu_res_m};
                {res_e, res_m} <= {fpu_res_e, fpu_res_m};
                res_valid <= 1'b1;
            end
        end
    end

    assign busy = state != IDLE;
    assign fpu_add = (state == ISSUE) & !op_sub;
    assign fpu_sub = (state == ISSUE) & op_sub;
    assign fpu_reg1_e = r1_e;
    assign fpu_reg1_m = r1_m;
    assign fpu_reg2_e = r2_e;
    assign fpu_reg2_m = r2_m;
endmodule
